bpu_mode_ctrl: RTL and testbench

//  Controller for the BPU predictor bank (not-taken, always-taken, 1-bit, 2-bit).

---
 rtl/bpu_mode_ctrl.sv | 152 +++++++++++++++
 tb/tb_bpu_mode_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_mode_ctrl.sv
// Mode controller for the BPU predictor bank: fixed selection or auto trial/commit/run.
// Optional free-running branch/mispredict counters are enabled by defining BPU_PERF_CNT_EN.
module bpu_mode_ctrl #(
  parameter int EPOCH_LEN = 64,
  parameter int RUN_LEN   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       br_resolve_EX,
  input  logic       mispredict_EX,
  input  logic       cfg_we_i,
  input  logic       cfg_auto_i,
  input  logic [1:0] cfg_sel_i,
  output logic [3:0] predictor_en_o,
  output logic       switch_flush_o,
  output logic [1:0] cur_sel_o,
  output logic [1:0] state_o
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0] perf_br_o,
  output logic [31:0] perf_miss_o
`endif
);

  typedef enum logic [1:0] {
    ST_FIXED = 2'd0,
    ST_TRIAL = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state;
  state_e           nxt_state;
  logic [1:0]       cur_sel;
  logic [1:0]       nxt_sel;
  logic [1:0]       slot;
  logic [1:0]       best;
  logic [CNT_W-1:0] epoch_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] miss       [4];
  logic [CNT_W-1:0] miss_final [4];
  logic [CNT_W-1:0] best_val;
  logic             br_hit;
  logic             miss_inc;
  logic             epoch_done;
  logic             run_done;

  // A cfg write in the same cycle as a resolved branch swallows the branch.
  assign br_hit     = br_resolve_EX & ~cfg_we_i;
  assign miss_inc   = br_hit & mispredict_EX & (state == ST_TRIAL) & (miss[slot] != '1);
  assign epoch_done = br_hit & (state == ST_TRIAL) & (epoch_cnt == CNT_W'(EPOCH_LEN - 1));
  assign run_done   = br_hit & (state == ST_RUN)   & (run_cnt   == CNT_W'(RUN_LEN - 1));

  // Miss counts including the current branch, so slot 3's final branch takes part in the commit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      miss_final[i] = miss[i];
      if (miss_inc && (slot == 2'(i))) miss_final[i] = miss[i] + 1'b1;
    end
    best     = 2'd0;
    best_val = miss_final[0];
    for (int i = 1; i < 4; i++) begin
      if (miss_final[i] < best_val) begin
        best     = 2'(i);
        best_val = miss_final[i];
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    nxt_state = state;
    nxt_sel   = cur_sel;
    if (cfg_we_i) begin
      nxt_state = cfg_auto_i ? ST_TRIAL : ST_FIXED;
      nxt_sel   = cfg_auto_i ? 2'd0 : cfg_sel_i;
    end else if (epoch_done) begin
      nxt_state = (slot == 2'd3) ? ST_RUN : ST_TRIAL;
      nxt_sel   = (slot == 2'd3) ? best : slot + 2'd1;
    end else if (run_done) begin
      nxt_state = ST_TRIAL;
      nxt_sel   = 2'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_FIXED;
      cur_sel        <= 2'd2;
      predictor_en_o <= 4'b0100;
      switch_flush_o <= 1'b0;
      slot           <= 2'd0;
      epoch_cnt      <= '0;
      run_cnt        <= '0;
      // NOTE: the four miss counters are tiny and must start at zero, so they are reset explicitly.
      for (int i = 0; i < 4; i++) miss[i] <= '0;
    end else begin
      state          <= nxt_state;
      cur_sel        <= nxt_sel;
      predictor_en_o <= 4'b0001 << nxt_sel;
      switch_flush_o <= (nxt_sel != cur_sel);
      if (cfg_we_i) begin
        slot      <= 2'd0;
        epoch_cnt <= '0;
        run_cnt   <= '0;
        if (cfg_auto_i) for (int i = 0; i < 4; i++) miss[i] <= '0;
      end else if (br_hit) begin
        case (state)
          ST_TRIAL: begin
            for (int i = 0; i < 4; i++) miss[i] <= miss_final[i];
            if (epoch_done) begin
              epoch_cnt <= '0;
              slot      <= slot + 2'd1;
              run_cnt   <= '0;
            end else begin
              epoch_cnt <= epoch_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (run_done) begin
              run_cnt   <= '0;
              epoch_cnt <= '0;
              slot      <= 2'd0;
              for (int i = 0; i < 4; i++) miss[i] <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cur_sel_o = cur_sel;
  assign state_o   = state;

`ifdef BPU_PERF_CNT_EN
  // Free-running: counted in every state, including cfg-write cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_br_o   <= '0;
      perf_miss_o <= '0;
    end else begin
      if (br_resolve_EX)                  perf_br_o   <= perf_br_o + 32'd1;
      if (br_resolve_EX && mispredict_EX) perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_mode_ctrl.sv
// Scoreboard bench for bpu_mode_ctrl (EPOCH_LEN=4, RUN_LEN=8); perf checks when BPU_PERF_CNT_EN is defined.
module tb_bpu_mode_ctrl;
  localparam int EPOCH_LEN = 4;
  localparam int RUN_LEN   = 8;
  localparam int CNT_W     = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       br_resolve_EX = 1'b0;
  logic       mispredict_EX = 1'b0;
  logic       cfg_we_i = 1'b0;
  logic       cfg_auto_i = 1'b0;
  logic [1:0] cfg_sel_i = 2'd0;
  logic [3:0] predictor_en_o;
  logic       switch_flush_o;
  logic [1:0] cur_sel_o;
  logic [1:0] state_o;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_br_o;
  logic [31:0] perf_miss_o;
`endif

  bpu_mode_ctrl #(.EPOCH_LEN(EPOCH_LEN), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .br_resolve_EX  (br_resolve_EX),
    .mispredict_EX  (mispredict_EX),
    .cfg_we_i       (cfg_we_i),
    .cfg_auto_i     (cfg_auto_i),
    .cfg_sel_i      (cfg_sel_i),
    .predictor_en_o (predictor_en_o),
    .switch_flush_o (switch_flush_o),
    .cur_sel_o      (cur_sel_o),
    .state_o        (state_o)
`ifdef BPU_PERF_CNT_EN
    ,
    .perf_br_o      (perf_br_o),
    .perf_miss_o    (perf_miss_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] en;
    logic       fl;
    logic [1:0] sel;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   flush_seen = 0;

  // Reference model state
  int   m_state, m_sel, m_slot, m_epoch, m_run;
  int   m_miss[4];

  task automatic model_reset();
    m_state = 0; m_sel = 2; m_slot = 0; m_epoch = 0; m_run = 0;
    for (int i = 0; i < 4; i++) m_miss[i] = 0;
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic cycle(input logic rst, input logic br, input logic mis,
                       input logic we, input logic au, input logic [1:0] sel);
    int   prev;
    int   b;
    exp_t e;
    exp_t got;
    rst_i = rst; br_resolve_EX = br; mispredict_EX = mis;
    cfg_we_i = we; cfg_auto_i = au; cfg_sel_i = sel;
    prev = m_sel;
    if (rst) begin
      model_reset();
    end else if (we) begin
      m_slot = 0; m_epoch = 0; m_run = 0;
      if (au) begin
        m_state = 1; m_sel = 0;
        for (int i = 0; i < 4; i++) m_miss[i] = 0;
      end else begin
        m_state = 0; m_sel = int'(sel);
      end
    end else if (br) begin
      if (m_state == 1) begin
        m_epoch++;
        if (mis && m_miss[m_slot] < 65535) m_miss[m_slot]++;
        if (m_epoch == EPOCH_LEN) begin
          m_epoch = 0;
          if (m_slot < 3) begin
            m_slot++; m_sel = m_slot;
          end else begin
            b = 0;
            for (int i = 1; i < 4; i++) if (m_miss[i] < m_miss[b]) b = i;
            m_sel = b; m_state = 2; m_run = 0; m_slot = 0;
          end
        end
      end else if (m_state == 2) begin
        m_run++;
        if (m_run == RUN_LEN) begin
          m_state = 1; m_sel = 0; m_slot = 0; m_epoch = 0; m_run = 0;
          for (int i = 0; i < 4; i++) m_miss[i] = 0;
        end
      end
    end
    e.en  = 4'(1 << m_sel);
    e.fl  = !rst && (m_sel != prev);
    e.sel = 2'(m_sel);
    e.st  = 2'(m_state);
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    total++;
    if (predictor_en_o !== got.en) begin
      bad++; $display("FAIL en t=%0t got=%b exp=%b", $time, predictor_en_o, got.en);
    end
    total++;
    if (switch_flush_o !== got.fl) begin
      bad++; $display("FAIL flush t=%0t got=%b exp=%b", $time, switch_flush_o, got.fl);
    end
    total++;
    if (cur_sel_o !== got.sel) begin
      bad++; $display("FAIL sel t=%0t got=%0d exp=%0d", $time, cur_sel_o, got.sel);
    end
    total++;
    if (state_o !== got.st) begin
      bad++; $display("FAIL state t=%0t got=%0d exp=%0d", $time, state_o, got.st);
    end
    if (switch_flush_o === 1'b1) flush_seen++;
  endtask

  task automatic branch(input logic mis);
    cycle(1'b0, 1'b1, mis, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    idle();
    total++;
    if (predictor_en_o !== 4'b0100 || cur_sel_o !== 2'd2 || state_o !== 2'd0 || switch_flush_o !== 1'b0) begin
      bad++; $display("FAIL reset_vals got en=%b sel=%0d st=%0d fl=%b exp en=0100 sel=2 st=0 fl=0",
                      predictor_en_o, cur_sel_o, state_o, switch_flush_o);
    end
  endtask

  task automatic test_fixed();
    flush_seen = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    total++;
    if (predictor_en_o !== 4'b1000 || switch_flush_o !== 1'b1) begin
      bad++; $display("FAIL fixed_sel got en=%b fl=%b exp en=1000 fl=1", predictor_en_o, switch_flush_o);
    end
    idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    idle();
    total++;
    if (flush_seen !== 1) begin
      bad++; $display("FAIL fixed_rewrite_pulses got=%0d exp=1", flush_seen);
    end
  endtask

  task automatic test_auto_trial();
    int misses[4] = '{3, 1, 2, 1};
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    total++;
    if (predictor_en_o !== 4'b0001 || switch_flush_o !== 1'b1 || state_o !== 2'd1) begin
      bad++; $display("FAIL auto_entry got en=%b fl=%b st=%0d exp en=0001 fl=1 st=1",
                      predictor_en_o, switch_flush_o, state_o);
    end
    flush_seen = 0;
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < EPOCH_LEN; j++) branch(j < misses[s]);
    total++;
    if (predictor_en_o !== 4'b0010 || state_o !== 2'd2) begin
      bad++; $display("FAIL auto_commit got en=%b st=%0d exp en=0010 st=2", predictor_en_o, state_o);
    end
    total++;
    if (flush_seen !== 4) begin
      bad++; $display("FAIL auto_pulses got=%0d exp=4", flush_seen);
    end
  endtask

  task automatic test_run_expiry();
    for (int i = 0; i < RUN_LEN - 1; i++) begin
      branch(1'b0); idle(); idle();
    end
    total++;
    if (state_o !== 2'd2) begin
      bad++; $display("FAIL run_not_expired got st=%0d exp=2", state_o);
    end
    branch(1'b0);
    total++;
    if (predictor_en_o !== 4'b0001 || switch_flush_o !== 1'b1 || state_o !== 2'd1) begin
      bad++; $display("FAIL run_expiry got en=%b fl=%b st=%0d exp en=0001 fl=1 st=1",
                      predictor_en_o, switch_flush_o, state_o);
    end
  endtask

  task automatic test_abort();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 2 * EPOCH_LEN + 1; i++) branch(i[0]);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    total++;
    if (predictor_en_o !== 4'b0010 || state_o !== 2'd0) begin
      bad++; $display("FAIL abort got en=%b st=%0d exp en=0010 st=0", predictor_en_o, state_o);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 4 * EPOCH_LEN; i++) branch(i % 3 == 0);
    branch(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    total++;
    if (predictor_en_o !== 4'b0100 || cur_sel_o !== 2'd2 || state_o !== 2'd0 || switch_flush_o !== 1'b0) begin
      bad++; $display("FAIL rst_in_run got en=%b sel=%0d st=%0d fl=%b exp en=0100 sel=2 st=0 fl=0",
                      predictor_en_o, cur_sel_o, state_o, switch_flush_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      logic we;
      we = ($urandom_range(0, 29) == 0);
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), we,
            1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    end
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
  endtask

`ifdef BPU_PERF_CNT_EN
  task automatic test_perf();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, (i == 1 || i == 4 || i == 7), (i == 5), 1'b1, 2'd0);
      if (i == 3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    total++;
    if (perf_br_o !== 32'd10) begin
      bad++; $display("FAIL perf_br got=%0d exp=10", perf_br_o);
    end
    total++;
    if (perf_miss_o !== 32'd3) begin
      bad++; $display("FAIL perf_miss got=%0d exp=3", perf_miss_o);
    end
  endtask
`endif

  initial begin
    model_reset();
    #2;
    test_reset();
    test_fixed();
    test_auto_trial();
    test_run_expiry();
    test_abort();
    test_back_to_back();
`ifdef BPU_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
